// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the instruction assembler and the opcode decoder.
package cpu_isa_pkg;

  // Instruction word geometry
  localparam int unsigned INST_W  = 16;
  localparam int unsigned FIELD_W = 4;

  // Field bit positions: [15:12] opcode, [11:8] Rd, [7:4] Rs1, [3:0] Rs2/imm
  localparam int unsigned OP_HI  = 15;
  localparam int unsigned OP_LO  = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 8;
  localparam int unsigned RS1_HI = 7;
  localparam int unsigned RS1_LO = 4;
  localparam int unsigned RS2_HI = 3;
  localparam int unsigned RS2_LO = 0;

  // Opcodes
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;
  localparam logic [3:0] OP_COPY  = 4'd3;
  localparam logic [3:0] OP_NOT   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_NAND  = 4'd8;
  localparam logic [3:0] OP_NOR   = 4'd9;
  localparam logic [3:0] OP_ADD   = 4'd10;
  localparam logic [3:0] OP_SUB   = 4'd11;
  localparam logic [3:0] OP_ADDI  = 4'd12;
  localparam logic [3:0] OP_SUBI  = 4'd13;
  localparam logic [3:0] OP_LSF   = 4'd14;
  localparam logic [3:0] OP_RSF   = 4'd15;

endpackage

// File: rtl/inst_encoder.sv
// Assembles a 16-bit instruction from four switch nibbles and offers it to the
// datapath over valid/ready. All outputs come straight from registers.
module inst_encoder
  import cpu_isa_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        nib_in,
  input  logic              nib_strobe,
  input  logic              cancel,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [1:0]        field_idx,
  output logic [CNT_W-1:0]  issue_cnt
);

  typedef enum logic [2:0] {
    S_OP,
    S_RD,
    S_RS1,
    S_RS2,
    S_ISSUE
  } state_t;

  state_t state;

  // FSM with registered word, valid, field index and issue counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_OP;
      inst       <= '0;
      inst_valid <= 1'b0;
      field_idx  <= 2'd0;
      issue_cnt  <= '0;
    end else begin
      unique case (state)
        S_OP: begin
          // cancel wins over a coincident strobe
          if (cancel) begin
            inst <= '0;
          end else if (nib_strobe) begin
            inst[OP_HI:OP_LO] <= nib_in;
            if (nib_in == OP_NOP) begin
              // a nop has no operands: issue it immediately with a clean body
              inst[RD_HI:0] <= '0;
              inst_valid    <= 1'b1;
              field_idx     <= 2'd0;
              state         <= S_ISSUE;
            end else begin
              field_idx <= 2'd1;
              state     <= S_RD;
            end
          end
        end

        S_RD: begin
          if (cancel) begin
            inst      <= '0;
            field_idx <= 2'd0;
            state     <= S_OP;
          end else if (nib_strobe) begin
            inst[RD_HI:RD_LO] <= nib_in;
            field_idx         <= 2'd2;
            state             <= S_RS1;
          end
        end

        S_RS1: begin
          if (cancel) begin
            inst      <= '0;
            field_idx <= 2'd0;
            state     <= S_OP;
          end else if (nib_strobe) begin
            inst[RS1_HI:RS1_LO] <= nib_in;
            field_idx           <= 2'd3;
            state               <= S_RS2;
          end
        end

        S_RS2: begin
          if (cancel) begin
            inst      <= '0;
            field_idx <= 2'd0;
            state     <= S_OP;
          end else if (nib_strobe) begin
            inst[RS2_HI:RS2_LO] <= nib_in;
            inst_valid          <= 1'b1;
            field_idx           <= 2'd0;
            state               <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // word is frozen until accepted; strobe and cancel are ignored here
          if (inst_ready) begin
            issue_cnt  <= issue_cnt + CNT_W'(1);
            inst       <= '0;
            inst_valid <= 1'b0;
            field_idx  <= 2'd0;
            state      <= S_OP;
          end
        end

        default: begin
          inst       <= '0;
          inst_valid <= 1'b0;
          field_idx  <= 2'd0;
          state      <= S_OP;
        end
      endcase
    end
  end

endmodule
